servo_pwm_decoder: RTL and testbench



---
 rtl/servo_pkg.sv | 29 ++
 rtl/servo_in_sync.sv | 45 ++++
 rtl/servo_pwm_decoder.sv | 146 ++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo timing constants, decoder state type and averaging helper
package servo_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    MIN,
    MEAS
  } servo_state_t;

  localparam int POS_W   = 8;
  localparam int POS_MAX = 255;

  // 10 MHz reference timing shared with the servo tester generator
  localparam int FRAME_TICKS       = 200000;
  localparam int MIN_TICKS_DEF     = 10000;
  localparam int TICKS_PER_LSB_DEF = 39;
  localparam int MAX_TICKS_DEF     = 25000;
  localparam int TIMEOUT_TICKS_DEF = 250000;
  localparam int CNT_W_DEF         = 18;

  function automatic logic [POS_W-1:0] avg_round(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
    logic [POS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 1'b1;
    return sum[POS_W:1];
  endfunction

endpackage

// File: rtl/servo_in_sync.sv
// rtl/servo_in_sync.sv - 2-FF synchronizer and ena-gated edge register for the servo pulse input
module servo_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic pwm_in,
  output logic sync,
  output logic rise,
  output logic fall,
  output logic primed
);

  logic       meta_q;
  logic       sync_q;
  logic       edge_q;
  logic [1:0] settle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      settle_q <= 2'b00;
    end else begin
      meta_q   <= pwm_in;
      sync_q   <= meta_q;
      settle_q <= {settle_q[0], 1'b1};
    end
  end

  // Holding the edge register while ena is low keeps a pending edge visible later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q <= 1'b0;
    end else if (ena) begin
      edge_q <= sync_q;
    end
  end

  assign sync   = sync_q;
  assign rise   = sync_q & ~edge_q;
  assign fall   = ~sync_q & edge_q;
  // sync only reflects the pin once the pipeline has refilled after reset
  assign primed = settle_q[1];

endmodule

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - RC servo pulse-width to 8-bit position decoder with glitch/timeout flags
// Define SERVO_DEC_FILTER_EN to average each accepted sample with the previous position.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int MIN_TICKS     = MIN_TICKS_DEF,
  parameter int TICKS_PER_LSB = TICKS_PER_LSB_DEF,
  parameter int MAX_TICKS     = MAX_TICKS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [POS_W-1:0] position,
  output logic             valid,
  output logic             sample_stb,
  output logic             err_stb
);

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_TICKS - 1);
  localparam logic [CNT_W-1:0] GLITCH_CNT  = CNT_W'(MIN_TICKS / 2);
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] TPL_LAST    = CNT_W'(TICKS_PER_LSB - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_TICKS);
  localparam logic [POS_W-1:0] ACC_MAX     = POS_W'(POS_MAX);

  logic sync;
  logic rise;
  logic fall;
  logic primed;

  servo_in_sync u_in_sync (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .pwm_in (pwm_in),
    .sync   (sync),
    .rise   (rise),
    .fall   (fall),
    .primed (primed)
  );

  servo_state_t     state, state_d;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_d;
  logic [CNT_W-1:0] presc, presc_d;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_d;
  logic [POS_W-1:0] pos_acc, pos_acc_d;
  logic [POS_W-1:0] position_d;
  logic             valid_d;
  logic             sample_d;
  logic             err_d;
  logic [CNT_W-1:0] pulse_inc;
  logic [POS_W-1:0] new_pos;

  assign pulse_inc = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + 1'b1;

`ifdef SERVO_DEC_FILTER_EN
  assign new_pos = valid ? avg_round(position, pos_acc) : pos_acc;
`else
  assign new_pos = pos_acc;
`endif

  // pulse_cnt holds the number of high cycles seen so far in the current pulse
  always_comb begin
    state_d     = state;
    pulse_cnt_d = pulse_cnt;
    presc_d     = presc;
    pos_acc_d   = pos_acc;
    frame_cnt_d = frame_cnt;
    position_d  = position;
    valid_d     = valid;
    sample_d    = 1'b0;
    err_d       = 1'b0;
    if (ena) begin
      if (frame_cnt != TIMEOUT_CNT) frame_cnt_d = frame_cnt + 1'b1;
      if (frame_cnt_d == TIMEOUT_CNT) valid_d = 1'b0;
      case (state)
        WAIT_LOW: begin
          if (primed && !sync) state_d = IDLE;
        end
        IDLE: begin
          if (rise) begin
            pulse_cnt_d = CNT_W'(1);
            presc_d     = '0;
            pos_acc_d   = '0;
            state_d     = MIN;
          end
        end
        MIN, MEAS: begin
          if (fall) begin
            if (pulse_cnt < GLITCH_CNT) begin
              err_d = 1'b1;
            end else begin
              position_d  = new_pos;
              sample_d    = 1'b1;
              valid_d     = 1'b1;
              frame_cnt_d = '0;
            end
            state_d = IDLE;
          end else if (sync && pulse_cnt >= MAX_CNT) begin
            err_d   = 1'b1;
            state_d = WAIT_LOW;
          end else if (sync) begin
            pulse_cnt_d = pulse_inc;
            if (state == MIN) begin
              if (pulse_cnt == MIN_LAST) state_d = MEAS;
            end else if (presc == TPL_LAST) begin
              presc_d = '0;
              if (pos_acc != ACC_MAX) pos_acc_d = pos_acc + 1'b1;
            end else begin
              presc_d = presc + 1'b1;
            end
          end
        end
        default: state_d = WAIT_LOW;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_LOW;
      pulse_cnt  <= '0;
      presc      <= '0;
      pos_acc    <= '0;
      frame_cnt  <= '0;
      position   <= '0;
      valid      <= 1'b0;
      sample_stb <= 1'b0;
      err_stb    <= 1'b0;
    end else begin
      state      <= state_d;
      pulse_cnt  <= pulse_cnt_d;
      presc      <= presc_d;
      pos_acc    <= pos_acc_d;
      frame_cnt  <= frame_cnt_d;
      position   <= position_d;
      valid      <= valid_d;
      sample_stb <= sample_d;
      err_stb    <= err_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - scoreboard bench for servo_pwm_decoder with a pulse-level reference model
module tb_servo_pwm_decoder;

  localparam int MIN_T = 100;
  localparam int TPL   = 2;
  localparam int MAX_T = 700;
  localparam int TMO   = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       pwm_in;
  logic [7:0] position;
  logic       valid;
  logic       sample_stb;
  logic       err_stb;

  typedef struct {
    bit is_err;
    int pos;
    int due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_pos;
  bit   model_valid;
  bit   last_glitch;
  int   last_smp_cyc;

  servo_pwm_decoder #(
    .MIN_TICKS     (MIN_T),
    .TICKS_PER_LSB (TPL),
    .MAX_TICKS     (MAX_T),
    .TIMEOUT_TICKS (TMO),
    .CNT_W         (18)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .position   (position),
    .valid      (valid),
    .sample_stb (sample_stb),
    .err_stb    (err_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int raw_pos(input int h);
    int r;
    r = (h > MIN_T) ? (h - MIN_T) / TPL : 0;
    return (r > 255) ? 255 : r;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && (sample_stb || err_stb)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: sample_stb=%0b err_stb=%0b, none expected (cycle %0d)",
                 sample_stb, err_stb, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {sample_stb, err_stb}, mon_e.is_err ? 1 : 2);
        check("strobe_cycle", cyc, mon_e.due);
        check("position", position, mon_e.pos);
        if (!mon_e.is_err) begin
          check("valid_on_sample", valid, 1);
          last_smp_cyc = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic low(input int n);
    pwm_in = 1'b0;
    tick(n);
  endtask

  // Drive a w-cycle high pulse; gap = ena-low cycles mid-pulse, tail = ena-low cycles from the fall
  task automatic pulse(input int w, input int gap, input int tail);
    int   n0;
    int   h;
    int   r;
    exp_t e;
    n0 = cyc;
    h  = w - gap - ((tail > 2) ? 2 : tail);
    last_glitch = 1'b0;
    if (h > MAX_T) begin
      e.is_err = 1'b1;
      e.pos    = model_pos;
      e.due    = n0 + 3 + MAX_T + gap;
    end else if (h < MIN_T / 2) begin
      e.is_err    = 1'b1;
      e.pos       = model_pos;
      e.due       = n0 + w + 3 + ((tail > 2) ? tail - 2 : 0);
      last_glitch = 1'b1;
    end else begin
      r = raw_pos(h);
`ifdef SERVO_DEC_FILTER_EN
      model_pos = model_valid ? (model_pos + r + 1) / 2 : r;
`else
      model_pos = r;
`endif
      model_valid = 1'b1;
      e.is_err    = 1'b0;
      e.pos       = model_pos;
      e.due       = n0 + w + 3 + ((tail > 2) ? tail - 2 : 0);
    end
    exp_q.push_back(e);
    pwm_in = 1'b1;
    for (int i = 0; i < w; i++) begin
      ena = !(gap > 0 && i >= 20 && i < 20 + gap);
      tick(1);
    end
    ena    = 1'b1;
    pwm_in = 1'b0;
    if (tail > 0) begin
      ena = 1'b0;
      tick(tail);
      ena = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    tick(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    int gap;
    int tail;
    reset        = 1'b1;
    ena          = 1'b1;
    pwm_in       = 1'b0;
    model_pos    = 0;
    model_valid  = 1'b0;
    last_glitch  = 1'b0;
    last_smp_cyc = 0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_position", position, 0);
    check("reset_valid", valid, 0);
    check("reset_sample_stb", sample_stb, 0);
    check("reset_err_stb", err_stb, 0);

    low(10); pulse(300, 0, 0);
    low(10); pulse(100, 0, 0);
    low(10); pulse(650, 0, 0);
    low(10); pulse(40, 0, 0);
    low(10); pulse(800, 0, 0);
    low(10); pulse(300, 0, 0);
    low(10);
    drain();

    n = 0;
    while (valid === 1'b1 && n < TMO + 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", cyc - last_smp_cyc, TMO);
    check("timeout_valid", valid, 0);
    check("timeout_position_hold", position, model_pos);
    model_valid = 1'b0;
    tick(1);

    pulse(300, 0, 0); low(10);
    pulse(500, 0, 0); low(10);
    pulse(300, 1, 0); low(10);
    pulse(300, 0, 4); low(10);
    drain();

    pwm_in = 1'b1;
    tick(150);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_pos   = 0;
    model_valid = 1'b0;
    tick(100);
    check("midpulse_reset_position", position, 0);
    check("midpulse_reset_valid", valid, 0);
    low(10);
    pulse(300, 0, 0);
    low(10);
    drain();

    for (int k = 0; k < 40; k++) begin
      if (!last_glitch && $urandom_range(0, 3) == 0) begin
        w    = $urandom_range(1, 46);
        tail = 0;
      end else begin
        w    = $urandom_range(56, 700);
        tail = $urandom_range(0, 3);
      end
      gap = (w >= 30) ? $urandom_range(0, 3) : 0;
      pulse(w, gap, tail);
      low($urandom_range(5, 60));
    end
    drain();
    check("final_valid", valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
